// File: rtl/score_keeper.sv
// Score keeper: converts asynchronous goal/new-game levels into single events,
// sequences hold-off and serve, and freezes scoring once a winner is reported.
module score_keeper #(
  parameter int unsigned HOLD_MS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_1ms,
  input  logic       goal_p1,
  input  logic       goal_p2,
  input  logic       new_game,
  input  logic [1:0] game_state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       serve,
  output logic       serving_player,
  output logic       goal_flash
);

  typedef enum logic [2:0] {IDLE, PLAY, HOLD, SERVE, OVER} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MS - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  p1_nx, p2_nx;
  logic        sp_nx;

  logic [2:0] raw, meta, sync, edge_q, ev_q;
  logic       ev_g1, ev_g2, ev_ng, won;

  assign raw = {new_game, goal_p2, goal_p1};

  // Event is registered so a level sampled at edge k acts on state at edge k+3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= '0;
      sync   <= '0;
      edge_q <= '0;
      ev_q   <= '0;
    end else begin
      meta   <= raw;
      sync   <= meta;
      edge_q <= sync;
      ev_q   <= sync & ~edge_q;
    end
  end

  assign ev_g1 = ev_q[0];
  assign ev_g2 = ev_q[1];
  assign ev_ng = ev_q[2];
  assign won   = (game_state == 2'b10) || (game_state == 2'b11);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    p1_nx    = p1_score;
    p2_nx    = p2_score;
    sp_nx    = serving_player;
    if ((state == PLAY || state == HOLD || state == SERVE) && won) begin
      state_nx = OVER;
    end else if (ev_ng) begin
      state_nx = HOLD;
      cnt_nx   = '0;
      p1_nx    = '0;
      p2_nx    = '0;
      sp_nx    = 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (ev_g1 || ev_g2) begin
            state_nx = HOLD;
            cnt_nx   = '0;
          end
          if (ev_g1 && !ev_g2) begin
            p1_nx = (p1_score == 4'd15) ? p1_score : p1_score + 4'd1;
            sp_nx = 1'b1;
          end else if (ev_g2 && !ev_g1) begin
            p2_nx = (p2_score == 4'd15) ? p2_score : p2_score + 4'd1;
            sp_nx = 1'b0;
          end
        end
        HOLD: begin
          if (clk_1ms) begin
            if (cnt == HOLD_LAST) state_nx = SERVE;
            else                  cnt_nx   = cnt + 16'd1;
          end
        end
        SERVE:   state_nx = PLAY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      p1_score       <= '0;
      p2_score       <= '0;
      serving_player <= 1'b0;
      serve          <= 1'b0;
      goal_flash     <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      p1_score       <= p1_nx;
      p2_score       <= p2_nx;
      serving_player <= sp_nx;
      serve          <= (state_nx == SERVE);
      goal_flash     <= (state_nx == HOLD);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus a random phase, all checked
// each cycle against a behavioural model of the scoring rules.
module tb_score_keeper;

  localparam int unsigned HMS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_1ms = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       new_game = 1'b0;
  logic [1:0] game_state = 2'b00;
  logic [3:0] p1_score, p2_score;
  logic       serve, serving_player, goal_flash;

  int checks = 0;
  int errors = 0;
  int serve_cnt = 0;
  logic last_sp = 1'b0;

  always #5 clk = ~clk;

  score_keeper #(.HOLD_MS(HMS)) dut (
    .clk(clk), .reset(reset), .clk_1ms(clk_1ms),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .new_game(new_game),
    .game_state(game_state),
    .p1_score(p1_score), .p2_score(p2_score),
    .serve(serve), .serving_player(serving_player), .goal_flash(goal_flash)
  );

  // Reference model: game phase, scores, ticks seen, and recent input history.
  typedef enum {M_IDLE, M_PLAY, M_HOLD, M_SERVE, M_OVER} mphase_t;
  mphase_t m_ph = M_IDLE;
  int m_p1 = 0, m_p2 = 0, m_sp = 0, m_ticks = 0;
  logic [4:0] h1 = '0, h2 = '0, hn = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_IDLE; m_p1 = 0; m_p2 = 0; m_sp = 0; m_ticks = 0;
    h1 = '0; h2 = '0; hn = '0;
  endtask

  task automatic start_hold(input bit clear);
    m_ph = M_HOLD;
    m_ticks = 0;
    if (clear) begin m_p1 = 0; m_p2 = 0; m_sp = 0; end
  endtask

  // Model view at each rising edge: an input seen 3 edges ago but not 4 is an event now.
  task automatic model_edge();
    bit e1, e2, en, over;
    if (!reset) begin model_reset(); return; end
    h1 = {h1[3:0], goal_p1};
    h2 = {h2[3:0], goal_p2};
    hn = {hn[3:0], new_game};
    e1 = h1[3] && !h1[4];
    e2 = h2[3] && !h2[4];
    en = hn[3] && !hn[4];
    over = game_state >= 2;
    if ((m_ph == M_PLAY || m_ph == M_HOLD || m_ph == M_SERVE) && over) m_ph = M_OVER;
    else if (en) start_hold(1);
    else begin
      case (m_ph)
        M_PLAY: begin
          if (e1 && !e2) begin m_p1 = (m_p1 + 1 > 15) ? 15 : m_p1 + 1; m_sp = 1; end
          if (e2 && !e1) begin m_p2 = (m_p2 + 1 > 15) ? 15 : m_p2 + 1; m_sp = 0; end
          if (e1 || e2) start_hold(0);
        end
        M_HOLD: if (clk_1ms) begin
          m_ticks++;
          if (m_ticks == HMS) m_ph = M_SERVE;
        end
        M_SERVE: m_ph = M_PLAY;
        default: ;
      endcase
    end
  endtask

  task automatic check_outs();
    chk("p1_score", p1_score, m_p1);
    chk("p2_score", p2_score, m_p2);
    chk("serve", serve, (m_ph == M_SERVE) ? 1 : 0);
    chk("serving_player", serving_player, m_sp);
    chk("goal_flash", goal_flash, (m_ph == M_HOLD) ? 1 : 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      if (serve === 1'b1) begin serve_cnt++; last_sp = serving_player; end
      check_outs();
    end
  endtask

  task automatic drive(input bit g1, input bit g2, input bit ng, input int len);
    goal_p1 = g1; goal_p2 = g2; new_game = ng;
    cyc(len);
    goal_p1 = 1'b0; goal_p2 = 1'b0; new_game = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      clk_1ms = 1'b1;
      cyc(1);
      clk_1ms = 1'b0;
      cyc(1 + int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    int sc;
    // Reset state
    cyc(3);
    chk("rst_p1", p1_score, 0);
    chk("rst_flash", goal_flash, 0);
    reset = 1'b1;
    cyc(2);

    // New game: hold-off then a single serve from P1
    drive(0, 0, 1, 1);
    cyc(4);
    chk("ng_flash", goal_flash, 1);
    sc = serve_cnt;
    ticks(HMS);
    cyc(2);
    chk("ng_serve_cnt", serve_cnt - sc, 1);
    chk("ng_serve_sp", last_sp, 0);
    game_state = 2'b01;

    // Held goal level scores exactly once, at the third edge after sampling
    goal_p1 = 1'b1;
    cyc(3);
    chk("g1_before", p1_score, 0);
    cyc(1);
    chk("g1_at_k3", p1_score, 1);
    chk("g1_sp", serving_player, 1);
    chk("g1_flash", goal_flash, 1);
    cyc(46);
    goal_p1 = 1'b0;
    chk("g1_once", p1_score, 1);
    ticks(HMS);
    cyc(3);

    // Simultaneous goals: no score, hold-off, serve keeps previous server
    drive(1, 1, 0, 2);
    cyc(4);
    chk("both_p1", p1_score, 1);
    chk("both_p2", p2_score, 0);
    chk("both_flash", goal_flash, 1);
    ticks(HMS);
    cyc(3);
    chk("both_serve_sp", last_sp, 1);

    // Fresh game, then P2 to 5 with a win reported
    drive(0, 0, 1, 1);
    cyc(4);
    ticks(HMS);
    cyc(3);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1);
      cyc(4);
      if (i < 4) begin ticks(HMS); cyc(3); end
    end
    game_state = 2'b11;
    sc = serve_cnt;
    cyc(2);
    ticks(HMS + 1);
    chk("won_no_serve", serve_cnt - sc, 0);
    chk("won_flash", goal_flash, 0);
    drive(1, 0, 0, 1); cyc(5);
    drive(0, 1, 0, 1); cyc(5);
    chk("over_p1", p1_score, 0);
    chk("over_p2", p2_score, 5);
    game_state = 2'b00;
    drive(0, 0, 1, 1);
    cyc(4);
    chk("restart_p2", p2_score, 0);
    chk("restart_flash", goal_flash, 1);
    chk("restart_sp", serving_player, 0);
    game_state = 2'b01;

    // Goal during hold-off is ignored; async reset mid-hold
    drive(1, 0, 0, 1);
    cyc(4);
    chk("hold_goal_ign", p1_score, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("arst_flash", goal_flash, 0);
    chk("arst_sp", serving_player, 0);
    cyc(2);
    reset = 1'b1;
    drive(1, 0, 0, 1);
    cyc(5);
    chk("idle_goal_ign", p1_score, 0);
    chk("idle_flash", goal_flash, 0);
    drive(0, 0, 1, 1);
    cyc(4);
    ticks(HMS);
    cyc(3);

    // Saturation at 15
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 1);
      cyc(4);
      ticks(HMS);
      cyc(3);
    end
    chk("sat_p1", p1_score, 15);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      goal_p1  = ($urandom_range(0, 7) == 0);
      goal_p2  = ($urandom_range(0, 7) == 0);
      new_game = ($urandom_range(0, 60) == 0);
      clk_1ms  = !clk_1ms && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 50) == 0) game_state = 2'($urandom_range(2, 3));
      else if ($urandom_range(0, 10) == 0) game_state = 2'($urandom_range(0, 1));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
